// File: rtl/inst_cache_if.sv
// PC-side fetch handshake and instruction-RAM port of the instruction cache.
interface inst_cache_if #(
    parameter int d_width = 16,
    parameter int a_width = 8
);
    logic [a_width-1:0] addr;
    logic               rd;
    logic               inval;
    logic [d_width-1:0] data_out;
    logic               odv;
    logic [a_width-1:0] ram_addr;
    logic               ram_re;
    logic [d_width-1:0] ram_data;
    logic               busy;

    modport slave  (input  addr, rd, inval, ram_data,
                    output data_out, odv, ram_addr, ram_re, busy);
    modport master (output addr, rd, inval, ram_data,
                    input  data_out, odv, ram_addr, ram_re, busy);
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache: 1-cycle hits, 3-cycle single-word
// fills from the instruction RAM.
module inst_cache #(
    parameter int d_width  = 16,
    parameter int a_width  = 8,
    parameter int idx_bits = 2
) (
    input  logic          g_clk,
    input  logic          g_clr,
    inst_cache_if.slave   bus
);
    localparam int LINES = 1 << idx_bits;
    localparam int TAG_W = a_width - idx_bits;

    typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

    state_t               state_q, state_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [a_width-1:0]   req_q, req_d;
    logic [d_width-1:0]   dout_q, dout_d;
    logic                 odv_q, odv_d;
    logic [a_width-1:0]   raddr_q, raddr_d;
    logic                 rre_q, rre_d;
    logic                 inv_pend_q, inv_pend_d;
    logic                 fill_we;

    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [d_width-1:0]   data_mem [LINES];

    logic [idx_bits-1:0]  idx, ridx;
    logic [TAG_W-1:0]     tag, rtag;
    logic                 hit;

    assign idx  = bus.addr[idx_bits-1:0];
    assign tag  = bus.addr[a_width-1:idx_bits];
    assign ridx = req_q[idx_bits-1:0];
    assign rtag = req_q[a_width-1:idx_bits];
    assign hit  = valid_q[idx] && (tag_mem[idx] == tag);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        req_d      = req_q;
        dout_d     = dout_q;
        odv_d      = 1'b0;
        raddr_d    = raddr_q;
        rre_d      = 1'b0;
        inv_pend_d = inv_pend_q;
        fill_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rd) begin
                    // invalidate wins over a same-cycle lookup, forcing a miss
                    if (hit && !bus.inval) begin
                        dout_d = data_mem[idx];
                        odv_d  = 1'b1;
                    end else begin
                        req_d      = bus.addr;
                        raddr_d    = bus.addr;
                        rre_d      = 1'b1;
                        inv_pend_d = 1'b0;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                if (bus.inval) inv_pend_d = 1'b1;
                state_d = FILL;
            end
            FILL: begin
                // an invalidate seen during the fill keeps the new line invalid
                fill_we       = 1'b1;
                valid_d[ridx] = !inv_pend_q;
                dout_d        = bus.ram_data;
                odv_d         = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.inval) valid_d = '0;
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            req_q      <= '0;
            dout_q     <= '0;
            odv_q      <= 1'b0;
            raddr_q    <= '0;
            rre_q      <= 1'b0;
            inv_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
            dout_q     <= dout_d;
            odv_q      <= odv_d;
            raddr_q    <= raddr_d;
            rre_q      <= rre_d;
            inv_pend_q <= inv_pend_d;
        end
    end

    always_ff @(posedge g_clk) begin
        if (fill_we) begin
            tag_mem[ridx]  <= rtag;
            data_mem[ridx] <= bus.ram_data;
        end
    end

    assign bus.data_out = dout_q;
    assign bus.odv      = odv_q;
    assign bus.ram_addr = raddr_q;
    assign bus.ram_re   = rre_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: directed vector table, multi-cycle corner sequences and
// a randomized run against a line-level cache model.
module tb_inst_cache;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    inst_cache_if #(.d_width(16), .a_width(8)) bus ();

    inst_cache #(.d_width(16), .a_width(8), .idx_bits(2)) dut (
        .g_clk(clk),
        .g_clr(clr),
        .bus  (bus)
    );

    logic [15:0] ram [256];
    always @(posedge clk) if (bus.ram_re) bus.ram_data <= ram[bus.ram_addr];

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  a;
        logic        inv;
        logic        hit;
        logic [15:0] d;
    } vec_t;
    vec_t tbl [13];

    // behavioural cache image: which address each line holds and its word
    logic        m_valid [4];
    logic [7:0]  m_addr  [4];
    logic [15:0] m_data  [4];

    function automatic logic [15:0] init_word(input logic [7:0] a);
        case (a)
            8'h10:   return 16'hA5C3;
            8'h14:   return 16'h1234;
            default: return {~a, a};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // presents one fetch, waits (bounded) for odv; lat=0 means it never came
    task automatic do_req(input logic [7:0] a, input logic inv, output int lat,
                          output int re_cnt, output logic [15:0] dat, output logic [7:0] re_addr);
        bus.rd = 1'b1; bus.addr = a; bus.inval = inv;
        lat = 0; re_cnt = 0; dat = '0; re_addr = '0;
        for (int n = 1; n <= 8; n++) begin
            step();
            bus.inval = 1'b0;
            if (bus.ram_re) begin re_cnt++; re_addr = bus.ram_addr; end
            if (bus.odv) begin lat = n; dat = bus.data_out; break; end
        end
        bus.rd = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, rc;
        logic [15:0] dat;
        logic [7:0] ra;

        for (int i = 0; i < 256; i++) ram[i] = init_word(8'(i));
        bus.rd = 1'b0; bus.addr = '0; bus.inval = 1'b0; bus.ram_data = '0;

        tbl[0]  = '{8'h10, 1'b0, 1'b0, 16'hA5C3};
        tbl[1]  = '{8'h10, 1'b0, 1'b1, 16'hA5C3};
        tbl[2]  = '{8'h14, 1'b0, 1'b0, 16'h1234};
        tbl[3]  = '{8'h10, 1'b0, 1'b0, 16'hA5C3};
        tbl[4]  = '{8'h20, 1'b0, 1'b0, 16'hDF20};
        tbl[5]  = '{8'h21, 1'b0, 1'b0, 16'hDE21};
        tbl[6]  = '{8'h22, 1'b0, 1'b0, 16'hDD22};
        tbl[7]  = '{8'h23, 1'b0, 1'b0, 16'hDC23};
        tbl[8]  = '{8'h21, 1'b0, 1'b1, 16'hDE21};
        tbl[9]  = '{8'h21, 1'b1, 1'b0, 16'hDE21};
        tbl[10] = '{8'h22, 1'b0, 1'b0, 16'hDD22};
        tbl[11] = '{8'h23, 1'b0, 1'b0, 16'hDC23};
        tbl[12] = '{8'h20, 1'b0, 1'b0, 16'hDF20};

        step(); step();
        clr = 1'b0;
        check("rst_odv", bus.odv, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_ram_re", bus.ram_re, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_busy", bus.busy, 0);

        for (int i = 0; i < 13; i++) begin
            do_req(tbl[i].a, tbl[i].inv, lat, rc, dat, ra);
            check($sformatf("v%0d_data", i), dat, tbl[i].d);
            check($sformatf("v%0d_latency", i), lat, tbl[i].hit ? 1 : 3);
            check($sformatf("v%0d_ram_re_cycles", i), rc, tbl[i].hit ? 0 : 1);
            if (!tbl[i].hit) check($sformatf("v%0d_ram_addr", i), ra, tbl[i].a);
        end

        // back-to-back hits on 0x20..0x23
        bus.rd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.addr = 8'h20 + 8'(k);
            step();
            check($sformatf("b2b%0d_odv", k), bus.odv, 1);
            check($sformatf("b2b%0d_data", k), bus.data_out, init_word(8'h20 + 8'(k)));
            check($sformatf("b2b%0d_ram_re", k), bus.ram_re, 0);
        end
        bus.rd = 1'b0;
        step();
        check("b2b_idle_odv", bus.odv, 0);
        check("b2b_idle_hold", bus.data_out, 16'hDC23);

        // invalidate while the 0x30 fill is in MISS; rd stays asserted throughout
        bus.rd = 1'b1; bus.addr = 8'h30;
        step();
        check("invmf_ram_re", bus.ram_re, 1);
        check("invmf_busy_miss", bus.busy, 1);
        check("invmf_odv_miss", bus.odv, 0);
        bus.inval = 1'b1;
        step();
        bus.inval = 1'b0;
        check("invmf_odv_fill", bus.odv, 0);
        check("invmf_busy_fill", bus.busy, 1);
        step();
        check("invmf_odv", bus.odv, 1);
        check("invmf_data", bus.data_out, 16'hCF30);
        check("invmf_busy_done", bus.busy, 0);
        step();
        check("invmf_rereq_ram_re", bus.ram_re, 1);
        check("invmf_rereq_odv", bus.odv, 0);
        step(); step();
        check("invmf_rereq_done", bus.odv, 1);
        bus.rd = 1'b0;
        step();

        // reset mid-fill: 0x21 made resident, then a 0x34 fill is aborted
        do_req(8'h21, 1'b0, lat, rc, dat, ra);
        do_req(8'h21, 1'b0, lat, rc, dat, ra);
        check("rmf_pre_hit_latency", lat, 1);
        bus.rd = 1'b1; bus.addr = 8'h34;
        step(); step();
        check("rmf_in_fill_busy", bus.busy, 1);
        clr = 1'b1;
        step();
        clr = 1'b0; bus.rd = 1'b0;
        check("rmf_odv", bus.odv, 0);
        check("rmf_busy", bus.busy, 0);
        check("rmf_ram_re", bus.ram_re, 0);
        check("rmf_data_out", bus.data_out, 0);
        step();
        check("rmf_no_late_odv", bus.odv, 0);
        do_req(8'h21, 1'b0, lat, rc, dat, ra);
        check("rmf_hit_candidate_latency", lat, 3);
        check("rmf_hit_candidate_data", dat, 16'hDE21);

        // randomized run from a clean cache
        clr = 1'b1; step(); clr = 1'b0;
        for (int l = 0; l < 4; l++) begin m_valid[l] = 1'b0; m_addr[l] = '0; m_data[l] = '0; end
        for (int it = 0; it < 150; it++) begin
            logic [7:0]  a;
            logic        inv, exp_hit;
            logic [15:0] exp_d;
            int          li;
            if ($urandom_range(0, 5) == 0)
                ram[8'h40 + 8'($urandom_range(0, 15))] = 16'($urandom);
            a   = 8'h40 + 8'($urandom_range(0, 15));
            inv = ($urandom_range(0, 9) == 0);
            li  = a % 4;
            if (inv) for (int l = 0; l < 4; l++) m_valid[l] = 1'b0;
            exp_hit = m_valid[li] && (m_addr[li] / 4 == a / 4);
            exp_d   = exp_hit ? m_data[li] : ram[a];
            if (!exp_hit) begin m_valid[li] = 1'b1; m_addr[li] = a; m_data[li] = ram[a]; end
            do_req(a, inv, lat, rc, dat, ra);
            check($sformatf("rnd%0d_data", it), dat, exp_d);
            check($sformatf("rnd%0d_latency", it), lat, exp_hit ? 1 : 3);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
